// File: rtl/klp32_pkg.sv
// Shared KLP32 definitions: fetch FSM encoding, instruction/PC widths and default vectors.
package klp32_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_STEP  = 4;

    localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN_DEF-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next fetch PC priority mux: trap, misaligned redirect, redirect, sequential step, hold.
module next_pc_sel
    import klp32_pkg::*;
#(
    parameter int unsigned          XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0]      TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF)
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc_c,
    output logic            misaligned_c,
    output logic            flush_c
);

    always_comb begin
        next_pc_c    = pc;
        misaligned_c = 1'b0;
        flush_c      = 1'b0;
        if (trap) begin
            next_pc_c = TRAP_VECTOR;
            flush_c   = 1'b1;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            // Unaligned branch target is reported as an exception.
            next_pc_c    = TRAP_VECTOR;
            misaligned_c = 1'b1;
            flush_c      = 1'b1;
        end else if (redirect_valid) begin
            next_pc_c = redirect_target;
            flush_c   = 1'b1;
        end else if (advance) begin
            next_pc_c = pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// KLP32 instruction-fetch controller: owns the fetch PC, runs the imem handshake,
// and hands instructions to decode with redirect/trap flushing.
module fetch_sequencer
    import klp32_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    input  logic               trap,
    output logic [XLEN-1:0]    pc_out,
    output logic               misaligned
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic            capture_c;
    logic            advance_c;
    logic            flush_c;
    logic            misaligned_c;
    logic [XLEN-1:0] next_pc_c;

    assign advance_c     = (state_q == ST_HOLD) && if_ready;
    assign imem_req_addr = pc_out;

    next_pc_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_pc_sel (
        .pc              (pc_out),
        .trap            (trap),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance_c),
        .next_pc_c       (next_pc_c),
        .misaligned_c    (misaligned_c),
        .flush_c         (flush_c)
    );

    // Next-state, kill tracking and capture strobe.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        capture_c = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    if (flush_c) kill_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush_c || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        capture_c = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (flush_c) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush_c || if_ready) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, PC and decode-facing registers; handshake outputs track the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            kill_q         <= 1'b0;
            pc_out         <= RESET_VECTOR;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_instr       <= '0;
            if_pc          <= '0;
            misaligned     <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            pc_out         <= next_pc_c;
            imem_req_valid <= (state_d == ST_REQ);
            if_valid       <= (state_d == ST_HOLD);
            misaligned     <= misaligned_c;
            if (capture_c) begin
                if_instr <= imem_rsp_data;
                if_pc    <= pc_out;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, redirect/trap flushing,
// misaligned redirect, PC wrap and asynchronous reset.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] pc_out;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .pc_out          (pc_out),
        .misaligned      (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ: zero-wait accept and response, ending in HOLD with the word presented.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        step();
        imem_rsp_valid = 1'b0;
        chk("if_valid", 32'(if_valid), 32'd1);
        chk("if_instr", if_instr, word);
        chk("if_pc", if_pc, addr);
    endtask

    task automatic accept();
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic with_trap);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        trap            = with_trap;
        step();
        redirect_valid  = 1'b0;
        trap            = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap            = 1'b0;

        #12;
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        reset = 1'b1;
        step();

        // Sequential fetch 0x0, 0x4 with a 5-cycle decode stall, then 0x8.
        do_fetch(32'h0, 32'h0051_0193);
        accept();
        do_fetch(32'h4, 32'h0010_0093);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_if_valid", 32'(if_valid), 32'd1);
            chk("stall_if_instr", if_instr, 32'h0010_0093);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        accept();
        do_fetch(32'h8, 32'h0020_8113);
        accept();

        // Redirect while waiting: late response at 0xC must be dropped.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect(32'h200, 1'b0);
        chk("wait_pc_out", pc_out, 32'h200);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wait_if_valid", 32'(if_valid), 32'd0);
            chk("wait_no_req", 32'(imem_req_valid), 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("drop_if_valid", 32'(if_valid), 32'd0);
        do_fetch(32'h200, 32'h0000_0013);

        // Trap beats a simultaneous redirect while holding.
        redirect(32'h400, 1'b1);
        chk("trap_if_valid", 32'(if_valid), 32'd0);
        do_fetch(32'h100, 32'h0000_0073);

        // Misaligned redirect from HOLD: one-cycle pulse and trap vector.
        redirect(32'h202, 1'b0);
        chk("mis_pulse", 32'(misaligned), 32'd1);
        chk("mis_addr", imem_req_addr, 32'h100);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        chk("mis_pulse_end", 32'(misaligned), 32'd0);

        // Redirect in REQ without ready, then with ready (old request issued, response dropped).
        redirect(32'h300, 1'b0);
        chk("req_redir_addr", imem_req_addr, 32'h300);
        chk("req_redir_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        redirect(32'h40, 1'b0);
        imem_req_ready = 1'b0;
        chk("reqrdy_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        step();
        imem_rsp_valid = 1'b0;
        chk("reqrdy_drop", 32'(if_valid), 32'd0);
        do_fetch(32'h40, 32'h0030_0193);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC, 1'b0);
        do_fetch(32'hFFFF_FFFC, 32'h0040_0213);
        accept();
        chk("wrap_addr", imem_req_addr, 32'h0);
        chk("wrap_valid", 32'(imem_req_valid), 32'd1);

        // Asynchronous reset in WAIT; a stale response afterwards is ignored.
        redirect(32'h500, 1'b0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("pre_rst_pc", pc_out, 32'h500);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_pc", pc_out, 32'h0);
        chk("async_rst_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        reset = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        chk("post_rst_if_valid", 32'(if_valid), 32'd0);
        do_fetch(32'h0, 32'h0051_0193);

        // Asynchronous reset while presenting an instruction.
        #3 reset = 1'b0;
        #1;
        chk("hold_rst_if_valid", 32'(if_valid), 32'd0);
        chk("hold_rst_if_instr", if_instr, 32'h0);
        reset = 1'b1;
        step();
        chk("hold_rst_req", 32'(imem_req_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
